// File: rtl/sync_fifo_prog_if.sv
// sync_fifo_prog bus: write/read requests, read data and status.
// master drives requests, slave is the FIFO.
interface sync_fifo_prog_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
);
  logic             wreq;
  logic [DSIZE-1:0] wdata;
  logic             rreq;
  logic [DSIZE-1:0] rdata;
  logic             rvalid;
  logic             wfull;
  logic             rempty;
  logic             almost_full;
  logic             almost_empty;
  logic [ASIZE:0]   level;
  logic             overflow;
  logic             underflow;

  modport master (
    output wreq, wdata, rreq,
    input  rdata, rvalid, wfull, rempty,
    input  almost_full, almost_empty,
    input  level, overflow, underflow
  );

  modport slave (
    input  wreq, wdata, rreq,
    output rdata, rvalid, wfull, rempty,
    output almost_full, almost_empty,
    output level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost flags,
// sticky error flags and optional first-word-fall-through.
module sync_fifo_prog #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = (1 << ASIZE) - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input logic clk,
  input logic rst_n,
  input logic clr,
  sync_fifo_prog_if.slave bus
);

  localparam int DEPTH = 1 << ASIZE;

  typedef logic [ASIZE:0] ptr_t;

  localparam ptr_t FULL_LVL = ptr_t'(DEPTH);
  localparam ptr_t AF_LVL   = ptr_t'(AFULL_TH);
  localparam ptr_t AE_LVL   = ptr_t'(AEMPTY_TH);
  localparam ptr_t ONE      = ptr_t'(1);

  logic [DSIZE-1:0] mem_q [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t level_q, level_d;

  logic wfull_q, wfull_d;
  logic rempty_q, rempty_d;
  logic afull_q, afull_d;
  logic aempty_q, aempty_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic rvalid_q, rvalid_d;

  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic [DSIZE-1:0] head;

  logic wr_acc;
  logic rd_acc;

  assign head   = mem_q[rd_ptr_q[ASIZE-1:0]];
  assign wr_acc = bus.wreq & ~wfull_q & ~clr;
  assign rd_acc = bus.rreq & ~rempty_q & ~clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
      if (wr_acc && !rd_acc) level_d = level_q + ONE;
      if (rd_acc && !wr_acc) level_d = level_q - ONE;
      ovf_d = ovf_q | (bus.wreq & wfull_q);
      unf_d = unf_q | (bus.rreq & rempty_q);
      if (rd_acc) begin
        rvalid_d = 1'b1;
        rdata_d  = head;
      end
    end
    // Flags follow the next-state level so they line up with level.
    wfull_d  = (level_d == FULL_LVL);
    rempty_d = (level_d == '0);
    afull_d  = (level_d >= AF_LVL);
    aempty_d = (level_d <= AE_LVL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[ASIZE-1:0]] <= bus.wdata;
  end

  assign bus.rdata        = (FWFT != 0) ? head : rdata_q;
  assign bus.rvalid       = (FWFT != 0) ? ~rempty_q : rvalid_q;
  assign bus.wfull        = wfull_q;
  assign bus.rempty       = rempty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a registered-read and a FWFT
// instance share stimulus and are scored against a queue model.
module tb_sync_fifo_prog;

  localparam int DEPTH = 4;
  localparam int AFT   = 3;
  localparam int AET   = 1;

  logic clk;
  logic rst_n;
  logic clr;

  sync_fifo_prog_if #(.DSIZE(8), .ASIZE(2)) if0 ();
  sync_fifo_prog_if #(.DSIZE(8), .ASIZE(2)) if1 ();

  sync_fifo_prog #(
    .DSIZE(8), .ASIZE(2), .AFULL_TH(AFT),
    .AEMPTY_TH(AET), .FWFT(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if0.slave)
  );

  sync_fifo_prog #(
    .DSIZE(8), .ASIZE(2), .AFULL_TH(AFT),
    .AEMPTY_TH(AET), .FWFT(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] mq[$];
  logic [7:0] exp0[$];
  bit ovf_m = 1'b0;
  bit unf_m = 1'b0;
  bit rv_exp = 1'b0;
  bit mon_en = 1'b0;

  function automatic void chk(string nm, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  task automatic drive(bit w, logic [7:0] d, bit r, bit c);
    if0.wreq = w; if0.wdata = d; if0.rreq = r;
    if1.wreq = w; if1.wdata = d; if1.rreq = r;
    clr = c;
  endtask

  task automatic model_reset();
    mq.delete();
    exp0.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    rv_exp = 1'b0;
  endtask

  // One clock of stimulus; the model advances at the edge.
  task automatic step(bit w, logic [7:0] d, bit r, bit c);
    bit full;
    bit empty;
    drive(w, d, r, c);
    @(posedge clk);
    rv_exp = 1'b0;
    if (c) begin
      mq.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      if (w && full) ovf_m = 1'b1;
      if (r && empty) unf_m = 1'b1;
      if (r && !empty) begin
        exp0.push_back(mq.pop_front());
        rv_exp = 1'b1;
      end
      if (w && !full) mq.push_back(d);
    end
    #1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      int lvl;
      lvl = mq.size();
      chk("level", int'(if0.level), lvl);
      chk("level_fwft", int'(if1.level), lvl);
      chk("wfull", int'(if0.wfull), int'(lvl == DEPTH));
      chk("rempty", int'(if0.rempty), int'(lvl == 0));
      chk("almost_full", int'(if0.almost_full), int'(lvl >= AFT));
      chk("almost_empty", int'(if0.almost_empty), int'(lvl <= AET));
      chk("overflow", int'(if0.overflow), int'(ovf_m));
      chk("underflow", int'(if0.underflow), int'(unf_m));
      chk("rvalid", int'(if0.rvalid), int'(rv_exp));
      if (if0.rvalid && exp0.size() != 0)
        chk("rdata", int'(if0.rdata), int'(exp0.pop_front()));
      chk("rvalid_fwft", int'(if1.rvalid), int'(lvl != 0));
      if (lvl != 0)
        chk("rdata_fwft", int'(if1.rdata), int'(mq[0]));
    end
  end

  task automatic reset_checks(string tag);
    chk({tag, "_level"}, int'(if0.level), 0);
    chk({tag, "_rempty"}, int'(if0.rempty), 1);
    chk({tag, "_aempty"}, int'(if0.almost_empty), 1);
    chk({tag, "_wfull"}, int'(if0.wfull), 0);
    chk({tag, "_afull"}, int'(if0.almost_full), 0);
    chk({tag, "_ovf"}, int'(if0.overflow), 0);
    chk({tag, "_unf"}, int'(if0.underflow), 0);
    chk({tag, "_rvalid"}, int'(if0.rvalid), 0);
    chk({tag, "_rdata"}, int'(if0.rdata), 0);
    chk({tag, "_rvalid_fwft"}, int'(if1.rvalid), 0);
  endtask

  initial begin
    logic [7:0] d;
    bit w;
    bit r;
    bit c;
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 reset_checks("por");
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill past full; the fifth write must be refused.
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    step(1, 8'h44, 0, 0);
    step(1, 8'h55, 0, 0);
    // Drain past empty.
    repeat (5) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // Write to empty then pop; FWFT shows the word unasked.
    step(1, 8'hA5, 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // Simultaneous read/write at full and at level 2.
    for (int i = 0; i < 4; i++) step(1, 8'h60 + 8'(i), 0, 0);
    step(1, 8'hEE, 1, 0);
    step(0, 8'h00, 1, 0);
    step(1, 8'h70, 1, 0);
    step(0, 8'h00, 1, 0);

    // Ten pairs at level 1 walk the pointers through two wraps.
    for (int i = 0; i < 10; i++) step(1, 8'h80 + 8'(i), 1, 0);
    step(0, 8'h00, 0, 0);

    // Flush at level 3 with overflow set and a write pending.
    step(1, 8'h91, 0, 0);
    step(1, 8'h92, 0, 0);
    step(1, 8'h93, 0, 0);
    step(1, 8'h94, 0, 0);
    step(1, 8'h95, 0, 0);
    step(0, 8'h00, 1, 0);
    step(1, 8'h96, 1, 1);
    step(0, 8'h00, 0, 0);

    // Asynchronous reset in the middle of a burst.
    step(1, 8'hB1, 0, 0);
    step(1, 8'hB2, 0, 0);
    step(1, 8'hB3, 1, 0);
    rst_n = 1'b0;
    #1 reset_checks("mid");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 8'hC1, 0, 0);
    step(1, 8'hC2, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // Random traffic with alternating fill/drain bias.
    for (int i = 0; i < 800; i++) begin
      d = 8'($urandom);
      if (((i / 100) % 2) == 0) begin
        w = ($urandom % 4) != 0;
        r = ($urandom % 4) == 0;
      end else begin
        w = ($urandom % 4) == 0;
        r = ($urandom % 4) != 0;
      end
      c = ($urandom % 50) == 0;
      step(w, d, r, c);
    end
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("pending_reads", exp0.size(), 0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
